// File: rtl/disp_scan.sv
// Four-digit multiplexed 7-segment scanner: steps one slot per rising edge of slow_clk,
// decodes BCD with leading-zero blanking, and registers anodes/segments together.
module disp_scan (
  input  logic        clk,
  input  logic        rst,
  input  logic        slow_clk,
  input  logic [15:0] digits,
  input  logic [3:0]  dp_in,
  input  logic        lz_blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  logic       r_s_q;
  logic [1:0] r_sel;
  logic [3:0] r_an;
  logic [6:0] r_seg;
  logic       r_dp;

  logic       w_tick;
  logic [3:0] w_digit;
  logic       w_blank;
  logic [3:0] w_an;
  logic [6:0] w_seg;
  logic       w_dp;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // A slot is blanked only while every digit from it leftwards is a literal zero;
  // dash codes are nonzero, so they stop the blanking run.
  function automatic logic slot_blank(input logic [1:0] sel, input logic [15:0] d,
                                      input logic lz);
    logic z3, z2, z1, b;
    z3 = (d[15:12] == 4'd0);
    z2 = (d[11:8]  == 4'd0);
    z1 = (d[7:4]   == 4'd0);
    case (sel)
      2'd3:    b = lz & z3;
      2'd2:    b = lz & z3 & z2;
      2'd1:    b = lz & z3 & z2 & z1;
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  assign w_tick = slow_clk & ~r_s_q;

  // Stage boundary: combinational slot selection and decode from the current sel.
  always_comb begin
    w_digit = digits[3:0];
    w_an    = 4'b1110;
    case (r_sel)
      2'd0: begin w_digit = digits[3:0];   w_an = 4'b1110; end
      2'd1: begin w_digit = digits[7:4];   w_an = 4'b1101; end
      2'd2: begin w_digit = digits[11:8];  w_an = 4'b1011; end
      default: begin w_digit = digits[15:12]; w_an = 4'b0111; end
    endcase
  end

  assign w_blank = slot_blank(r_sel, digits, lz_blank);

  always_comb begin
    w_seg = seg_decode(w_digit);
    w_dp  = ~dp_in[r_sel];
    if (w_blank) begin
      w_seg = 7'b1111111;
      w_dp  = 1'b1;
    end
  end

  // Stage boundary: edge detector, scan counter and output registers share one edge,
  // so anodes and segments always switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_q <= 1'b1;
      r_sel <= 2'd0;
      r_an  <= 4'b1111;
      r_seg <= 7'b1111111;
      r_dp  <= 1'b1;
    end else begin
      r_s_q <= slow_clk;
      if (w_tick) r_sel <= r_sel + 2'd1;
      r_an  <= w_blank ? 4'b1111 : w_an;
      r_seg <= w_seg;
      r_dp  <= w_dp;
    end
  end

  assign an  = r_an;
  assign seg = r_seg;
  assign dp  = r_dp;

endmodule

// File: doc/disp_scan.md
DISP_SCAN -- requirements
Module: disp_scan

Interface
REQ-001 The block SHALL have exactly one clock and one reset: `clk`, and `rst`, which is synchronous and active-high.
REQ-002 Ports SHALL be, in order (name, direction, width, meaning):
- `clk` input 1: system clock; all state updates on its rising edge.
- `rst` input 1: synchronous active-high reset.
- `slow_clk` input 1: divided scan clock from the display divider; sampled as data, never used as a clock.
- `digits` input 16: four BCD digits. [3:0] is digit0 (rightmost); [15:12] is digit3 (leftmost).
- `dp_in` input 4: decimal-point request, one bit per digit, 1 = lit; bit n belongs to digit n.
- `lz_blank` input 1: 1 enables leading-zero blanking.
- `an` output 4: digit anodes, active-low; bit n drives digit n.
- `seg` output 7: segment cathodes, active-low, ordered [6:0] = g,f,e,d,c,b,a.
- `dp` output 1: decimal-point cathode, active-low.

Function
REQ-003 `slow_clk` SHALL be registered into `s_q` every clk. `tick` = `slow_clk` & ~`s_q` (rising edge) SHALL be exactly one clk wide per `slow_clk` rising edge.
REQ-004 A 2-bit scan counter `sel` SHALL increment by 1 on each `tick` and wrap from 3 to 0. It SHALL hold its value otherwise.
REQ-005 `an`, `seg` and `dp` SHALL be registered and SHALL reflect the `sel`, `digits`, `dp_in` and `lz_blank` values of the previous clk (1-clk latency).
REQ-006 For an unblanked slot, `an` SHALL be one-hot low: sel=0 -> 1110, 1 -> 1101, 2 -> 1011, 3 -> 0111.
REQ-007 Segment decode for the selected digit SHALL be:
- 0 -> 1000000
- 1 -> 1111001
- 2 -> 0100100
- 3 -> 0110000
- 4 -> 0011001
- 5 -> 0010010
- 6 -> 0000010
- 7 -> 1111000
- 8 -> 0000000
- 9 -> 0010000
- 10..15 -> 0111111 (dash)
REQ-008 `dp` SHALL be ~`dp_in`[sel] for an unblanked slot.
REQ-009 When `lz_blank`=1, blanking SHALL apply as follows:
- digit3 is blanked if it is 0.
- digit2 is blanked if digit3 and digit2 are both 0.
- digit1 is blanked if digits 3..1 are all 0.
- digit0 is never blanked.
- A dash value (10..15) is never treated as zero.
REQ-010 A blanked slot SHALL drive `an`=1111, `seg`=1111111, `dp`=1, and the scan SHALL still spend the full slot on it.
REQ-011 `digits`, `dp_in` and `lz_blank` SHALL NOT be latched per slot. A change SHALL appear on the outputs within 1 clk, even mid-slot.
REQ-012 If `slow_clk` is held constant, no `tick` SHALL occur. `sel` SHALL freeze, and the displayed slot SHALL continue to track input changes.
REQ-013 `an` and `seg` SHALL change in the same clk edge, so that no cycle shows new anodes with stale segments.

Reset
REQ-014 While `rst`=1 the block SHALL set `s_q`<=1, `sel`<=0, `an`<=1111, `seg`<=1111111 and `dp`<=1. `rst` SHALL override a simultaneous `tick`.
REQ-015 Because `s_q` resets to 1, a `slow_clk` that is high at reset release SHALL NOT produce a `tick`. The first clk after release SHALL output slot 0.
REQ-016 Reset asserted mid-scan SHALL return `sel` to 0 with no partial-slot artefacts after release.

Verification
REQ-017 A bench SHALL cover the following directed scenarios:
- **Reset with slow_clk high:** `rst`=1 for 3 clk, `slow_clk`=1, `digits`=16'h1234. Outputs = 1111 / 1111111 / 1 during reset. After release, 1 clk later `an`=1110, `seg`=0011001, and it stays there while `slow_clk` remains 1.
- **Full scan:** `digits`=16'h1234, `lz_blank`=0, `dp_in`=0, `slow_clk` period 8 clk. The slots SHALL show:

  | `an` | `seg` |
  |------|-------|
  | 1110 | 0011001 |
  | 1101 | 0110000 |
  | 1011 | 0100100 |
  | 0111 | 1111001 |

  The sequence then repeats from 1110, and `dp` stays 1.
- **Leading-zero blanking:** `lz_blank`=1, `digits`=16'h0005. Slots 1..3 give `an`=1111 with `seg`=1111111. Slot 0 gives `an`=1110 with `seg`=0010010. With `digits`=16'h0000, slot 0 shows 1000000.
- **Dash and decimal point:** `digits`=16'h000A, `lz_blank`=0. Slot 0 gives `seg`=0111111. With `dp_in`=0100, `dp`=0 only while `an`=1011.
- **Reset mid-scan:** `rst` pulsed 1 clk while `sel`=2. The next clk shows all blank, then slot 0 follows. No `tick` SHALL be generated by a `slow_clk` that is already high.
- **Edge-detect width:** `slow_clk` held high 20 clk. Exactly one `sel` increment occurs. A mid-slot `digits` change appears on `seg` 1 clk later.
